// File: rtl/lbm_pkg.sv
// Shared types and constants for the LBM lattice pipeline.
package lbm_pkg;

  localparam int unsigned LBM_DEPTH          = 2500;
  localparam int unsigned LBM_DATA_W         = 16;
  localparam int unsigned LBM_DIRS           = 9;
  localparam int unsigned LBM_STREAM_W       = LBM_DATA_W * LBM_DIRS;
  localparam int unsigned LBM_EXPECTED_BEATS = 2500;
  localparam int unsigned LBM_BEAT_W         = 12;
  localparam int unsigned LBM_SPF_W          = 8;
  localparam int unsigned LBM_STALL_LIMIT    = 1023;
  localparam int unsigned LBM_FRAME_CNT_W    = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    STEP_WAIT,
    SWITCH,
    FRAME,
    STREAM,
    RELEASE
  } lbm_state_t;

  // One stream beat: all nine distribution values of one lattice cell.
  typedef struct packed {
    logic [LBM_DIRS-1:0][LBM_DATA_W-1:0] f;
  } lbm_beat_t;

endpackage

// File: rtl/lbm_frame_sched_if.sv
// Run control, compute handshake, stream snoop and status of the frame scheduler.
interface lbm_frame_sched_if
  import lbm_pkg::*;
#(
  parameter int unsigned SPF_W = LBM_SPF_W
);

  logic                       run;
  logic [SPF_W-1:0]           steps_per_frame;
  logic                       step_done;
  logic                       m00_axis_tvalid;
  logic                       m00_axis_tready;
  logic                       m00_axis_tlast;
  logic                       step_start;
  logic                       frame_ready;
  logic                       bram_sel;
  logic                       busy;
  logic [SPF_W-1:0]           step_count;
  logic [LBM_FRAME_CNT_W-1:0] frame_count;
  logic                       err_len;
  logic                       err_step;
  logic                       err_stall;

  // Scheduler view.
  modport master (
    input  run, steps_per_frame, step_done,
    input  m00_axis_tvalid, m00_axis_tready, m00_axis_tlast,
    output step_start, frame_ready, bram_sel, busy,
    output step_count, frame_count, err_len, err_step, err_stall
  );

  // Environment view: host, compute engine and readout side.
  modport slave (
    output run, steps_per_frame, step_done,
    output m00_axis_tvalid, m00_axis_tready, m00_axis_tlast,
    input  step_start, frame_ready, bram_sel, busy,
    input  step_count, frame_count, err_len, err_step, err_stall
  );

endinterface

// File: rtl/lbm_stream_monitor.sv
// Snoops the readout stream: beat/stall counting and length/stall error flags.
module lbm_stream_monitor
  import lbm_pkg::*;
#(
  parameter int unsigned EXPECTED_BEATS = LBM_EXPECTED_BEATS,
  parameter int unsigned BEAT_W         = LBM_BEAT_W,
  parameter int unsigned STALL_LIMIT    = LBM_STALL_LIMIT
) (
  input  logic m00_axis_aclk,
  input  logic m00_axis_aresetn,
  input  logic clr,
  input  logic en,
  input  logic tvalid,
  input  logic tready,
  input  logic tlast,
  output logic last_beat_c,
  output logic err_len,
  output logic err_stall
);

  localparam int unsigned          STALL_W   = $clog2(STALL_LIMIT + 1);
  localparam logic [BEAT_W-1:0]    BEAT_EXP  = BEAT_W'(EXPECTED_BEATS);
  localparam logic [STALL_W-1:0]   STALL_MAX = STALL_W'(STALL_LIMIT);

  logic               beat_c;
  logic [BEAT_W-1:0]  beat_q, beat_d, beat_inc_c;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               err_len_q, err_len_d;
  logic               err_stall_q, err_stall_d;

  // Next-state for counters and sticky error flags.
  always_comb begin
    beat_c      = en & tvalid & tready;
    last_beat_c = beat_c & tlast;
    beat_inc_c  = (&beat_q) ? beat_q : beat_q + BEAT_W'(1);
    beat_d      = beat_q;
    stall_d     = stall_q;
    err_len_d   = err_len_q;
    err_stall_d = err_stall_q;
    if (clr) begin
      beat_d  = '0;
      stall_d = '0;
    end else if (beat_c) begin
      beat_d  = beat_inc_c;
      stall_d = '0;
      if (tlast && (beat_inc_c != BEAT_EXP)) err_len_d = 1'b1;
    end else if (en) begin
      if (stall_q != STALL_MAX) stall_d = stall_q + STALL_W'(1);
      if (stall_d == STALL_MAX) err_stall_d = 1'b1;
    end
  end

  // Counter and flag registers.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      beat_q      <= '0;
      stall_q     <= '0;
      err_len_q   <= 1'b0;
      err_stall_q <= 1'b0;
    end else begin
      beat_q      <= beat_d;
      stall_q     <= stall_d;
      err_len_q   <= err_len_d;
      err_stall_q <= err_stall_d;
    end
  end

  assign err_len   = err_len_q;
  assign err_stall = err_stall_q;

endmodule

// File: rtl/lbm_frame_sched.sv
// Top-level sequencer: compute steps, BRAM port hand-over and frame readout.
module lbm_frame_sched
  import lbm_pkg::*;
#(
  parameter int unsigned EXPECTED_BEATS = LBM_EXPECTED_BEATS,
  parameter int unsigned BEAT_W         = LBM_BEAT_W,
  parameter int unsigned SPF_W          = LBM_SPF_W,
  parameter int unsigned STALL_LIMIT    = LBM_STALL_LIMIT
) (
  input logic               m00_axis_aclk,
  input logic               m00_axis_aresetn,
  lbm_frame_sched_if.master bus
);

  lbm_state_t                 state_q, state_d;
  logic [SPF_W-1:0]           step_count_q, step_count_d;
  logic [SPF_W-1:0]           spf_q, spf_d;
  logic [LBM_FRAME_CNT_W-1:0] frame_count_q, frame_count_d;
  logic                       step_start_q, step_start_d;
  logic                       frame_ready_q, frame_ready_d;
  logic                       bram_sel_q, bram_sel_d;
  logic                       busy_q, busy_d;
  logic                       err_step_q, err_step_d;
  logic                       mon_clr_c, mon_en_c, last_beat_c;
  logic                       err_len_w, err_stall_w;

  lbm_stream_monitor #(
    .EXPECTED_BEATS (EXPECTED_BEATS),
    .BEAT_W         (BEAT_W),
    .STALL_LIMIT    (STALL_LIMIT)
  ) u_mon (
    .m00_axis_aclk    (m00_axis_aclk),
    .m00_axis_aresetn (m00_axis_aresetn),
    .clr              (mon_clr_c),
    .en               (mon_en_c),
    .tvalid           (bus.m00_axis_tvalid),
    .tready           (bus.m00_axis_tready),
    .tlast            (bus.m00_axis_tlast),
    .last_beat_c      (last_beat_c),
    .err_len          (err_len_w),
    .err_stall        (err_stall_w)
  );

  // Next-state and output decode; outputs follow the state one cycle later.
  always_comb begin
    state_d       = state_q;
    step_count_d  = step_count_q;
    spf_d         = spf_q;
    frame_count_d = frame_count_q;
    err_step_d    = err_step_q;
    step_start_d  = (state_q == START);
    frame_ready_d = (state_q == FRAME);
    bram_sel_d    = (state_q == SWITCH) || (state_q == FRAME) || (state_q == STREAM);
    busy_d        = (state_q != IDLE);
    mon_clr_c     = (state_q == FRAME);
    mon_en_c      = (state_q == STREAM);
    if (bus.step_done && (state_q != STEP_WAIT)) err_step_d = 1'b1;
    case (state_q)
      IDLE: if (bus.run) state_d = START;
      START: begin
        if (step_count_q == '0)
          spf_d = (bus.steps_per_frame == '0) ? SPF_W'(1) : bus.steps_per_frame;
        state_d = STEP_WAIT;
      end
      STEP_WAIT: begin
        if (bus.step_done) begin
          step_count_d = step_count_q + SPF_W'(1);
          if (step_count_d == spf_q) state_d = SWITCH;
          else if (bus.run)          state_d = START;
          else                       state_d = IDLE;
        end
      end
      SWITCH: state_d = FRAME;
      FRAME:  state_d = STREAM;
      STREAM: begin
        if (last_beat_c) begin
          frame_count_d = frame_count_q + LBM_FRAME_CNT_W'(1);
          state_d       = RELEASE;
        end
      end
      RELEASE: begin
        step_count_d = '0;
        state_d      = bus.run ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state_q       <= IDLE;
      step_count_q  <= '0;
      spf_q         <= SPF_W'(1);
      frame_count_q <= '0;
      step_start_q  <= 1'b0;
      frame_ready_q <= 1'b0;
      bram_sel_q    <= 1'b0;
      busy_q        <= 1'b0;
      err_step_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_count_q  <= step_count_d;
      spf_q         <= spf_d;
      frame_count_q <= frame_count_d;
      step_start_q  <= step_start_d;
      frame_ready_q <= frame_ready_d;
      bram_sel_q    <= bram_sel_d;
      busy_q        <= busy_d;
      err_step_q    <= err_step_d;
    end
  end

  assign bus.step_start  = step_start_q;
  assign bus.frame_ready = frame_ready_q;
  assign bus.bram_sel    = bram_sel_q;
  assign bus.busy        = busy_q;
  assign bus.step_count  = step_count_q;
  assign bus.frame_count = frame_count_q;
  assign bus.err_len     = err_len_w;
  assign bus.err_step    = err_step_q;
  assign bus.err_stall   = err_stall_w;

endmodule

// File: tb/tb_lbm_frame_sched.sv
// Directed/randomized bench for lbm_frame_sched with a compute-engine responder.
module tb_lbm_frame_sched;

  localparam int unsigned EXP_BEATS = 2500;
  localparam int          STALL_LIM = 1023;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lbm_frame_sched_if #(.SPF_W(8)) bus ();

  lbm_frame_sched #(
    .EXPECTED_BEATS (EXP_BEATS),
    .BEAT_W         (12),
    .SPF_W          (8),
    .STALL_LIMIT    (STALL_LIM)
  ) dut (
    .m00_axis_aclk    (clk),
    .m00_axis_aresetn (rst_n),
    .bus              (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int cyc = 0;
  int cur_starts = 0, frame_starts = 0, n_fr = 0;
  int last_done_cyc = 0, fr_cyc = 0, bram_viol = 0;
  logic eng_done = 1'b0, spur_done = 1'b0;
  int eng_lat = 5, pend = 0;

  int exp_fc = 0;
  bit exp_err_len = 0, exp_err_stall = 0;
  int spf_next;
  int n0;

  assign bus.step_done = eng_done | spur_done;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) cur_starts = 0;
    else begin
      if (bus.step_start) cur_starts++;
      if (bus.step_done) last_done_cyc = cyc;
      if (bus.frame_ready) begin
        frame_starts = cur_starts;
        cur_starts   = 0;
        n_fr++;
        fr_cyc = cyc;
      end
      if (bus.m00_axis_tvalid && bus.m00_axis_tready && bus.bram_sel !== 1'b1) bram_viol++;
    end
  end

  // Compute engine: answers each step_start with step_done eng_lat cycles later.
  always @(posedge clk) begin
    #1;
    eng_done = 1'b0;
    if (!rst_n) pend = 0;
    else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) eng_done = 1'b1;
      end
      if (bus.step_start) pend = eng_lat;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic wait_fr(input int target, input string tag);
    int budget = 0;
    while (n_fr < target && budget < 2000) begin
      tick();
      budget++;
    end
    chk(tag, n_fr, target);
  endtask

  task automatic wait_starts(input int target, input string tag);
    int budget = 0;
    while (cur_starts < target && budget < 500) begin
      tick();
      budget++;
    end
    chk(tag, cur_starts, target);
  endtask

  // Source one frame of len beats; tready withheld for stall_len cycles at beat stall_at.
  task automatic stream_frame(input int len, input int stall_at, input int stall_len, input bit gappy);
    int sent = 0;
    int idle = 0;
    bit v, r;
    while (sent < len) begin
      v = gappy ? ($urandom_range(0, 3) != 0) : 1'b1;
      r = !(sent == stall_at && idle < stall_len);
      bus.m00_axis_tvalid = v;
      bus.m00_axis_tready = r;
      bus.m00_axis_tlast  = (sent == len - 1);
      tick();
      if (!r) begin
        idle++;
        if (idle == STALL_LIM - 1) chk("stall_before_limit", 32'(bus.err_stall), 32'(exp_err_stall));
        if (idle == STALL_LIM) begin
          exp_err_stall = 1'b1;
          chk("stall_at_limit", 32'(bus.err_stall), 32'(exp_err_stall));
        end
        if (idle == stall_len) begin
          chk("stall_busy", 32'(bus.busy), 32'd1);
          chk("stall_bram_sel", 32'(bus.bram_sel), 32'd1);
          chk("stall_frame_count", 32'(bus.frame_count), 32'(exp_fc));
        end
      end
      if (v && r) sent++;
    end
    bus.m00_axis_tvalid = 1'b0;
    bus.m00_axis_tlast  = 1'b0;
    bus.m00_axis_tready = 1'b1;
  endtask

  // Checks right after the tlast beat; run is assumed high.
  task automatic after_frame(input string tag, input int len);
    exp_fc = (exp_fc + 1) % 65536;
    if (len != int'(EXP_BEATS)) exp_err_len = 1'b1;
    chk({tag, "_frame_count"}, 32'(bus.frame_count), 32'(exp_fc));
    chk({tag, "_err_len"}, 32'(bus.err_len), 32'(exp_err_len));
    chk({tag, "_err_stall"}, 32'(bus.err_stall), 32'(exp_err_stall));
    chk({tag, "_err_step"}, 32'(bus.err_step), 32'd0);
    chk({tag, "_bram_during_stream"}, bram_viol, 32'd0);
    chk({tag, "_bram_hold"}, 32'(bus.bram_sel), 32'd1);
    tick();
    chk({tag, "_bram_release"}, 32'(bus.bram_sel), 32'd0);
    tick();
    chk({tag, "_restart"}, 32'(bus.step_start), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.run = 1'b0;
    bus.steps_per_frame = '0;
    bus.m00_axis_tvalid = 1'b0;
    bus.m00_axis_tready = 1'b0;
    bus.m00_axis_tlast  = 1'b0;
    repeat (3) tick();
    chk("rst_step_start", 32'(bus.step_start), 32'd0);
    chk("rst_frame_ready", 32'(bus.frame_ready), 32'd0);
    chk("rst_bram_sel", 32'(bus.bram_sel), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_step_count", 32'(bus.step_count), 32'd0);
    chk("rst_frame_count", 32'(bus.frame_count), 32'd0);
    chk("rst_errs", 32'({bus.err_len, bus.err_step, bus.err_stall}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    bus.m00_axis_tready = 1'b1;

    // Frame 1: spf=3, exact length; spf change mid-frame must not apply.
    bus.steps_per_frame = 8'd3;
    bus.run = 1'b1;
    tick();
    chk("run_lat_early", 32'(bus.step_start), 32'd0);
    tick();
    chk("run_lat", 32'(bus.step_start), 32'd1);
    chk("run_busy", 32'(bus.busy), 32'd1);
    wait_starts(2, "f1_second_start");
    bus.steps_per_frame = 8'd7;
    wait_fr(1, "f1_frame_ready");
    chk("f1_steps", frame_starts, 32'd3);
    chk("f1_fr_lat", fr_cyc - last_done_cyc, 32'd3);
    bus.steps_per_frame = 8'd3;
    stream_frame(EXP_BEATS, -1, 0, 1'b0);
    after_frame("f1", EXP_BEATS);

    // Frame 2: tlast one beat late.
    wait_fr(2, "f2_frame_ready");
    chk("f2_steps", frame_starts, 32'd3);
    chk("f2_fr_lat", fr_cyc - last_done_cyc, 32'd3);
    bus.steps_per_frame = 8'd0;
    stream_frame(EXP_BEATS + 1, -1, 0, 1'b0);
    after_frame("f2", EXP_BEATS + 1);

    // Frame 3: spf=0 behaves as 1; random engine latency, gappy stream.
    eng_lat = $urandom_range(1, 8);
    wait_fr(3, "f3_frame_ready");
    chk("f3_steps", frame_starts, 32'd1);
    chk("f3_fr_lat", fr_cyc - last_done_cyc, 32'd3);
    spf_next = $urandom_range(1, 3);
    bus.steps_per_frame = 8'(spf_next);
    stream_frame(EXP_BEATS, -1, 0, 1'b1);
    after_frame("f3", EXP_BEATS);

    // Frame 4: long sink stall mid-frame.
    eng_lat = $urandom_range(1, 8);
    wait_fr(4, "f4_frame_ready");
    chk("f4_steps", frame_starts, 32'(spf_next));
    chk("f4_fr_lat", fr_cyc - last_done_cyc, 32'd3);
    bus.steps_per_frame = 8'd4;
    eng_lat = 5;
    stream_frame(EXP_BEATS, 1000, 1100, 1'b0);
    after_frame("f4", EXP_BEATS);

    // Frame 5: run dropped during the second step.
    wait_starts(2, "f5_second_start");
    bus.run = 1'b0;
    repeat (15) tick();
    chk("f5_paused_step_count", 32'(bus.step_count), 32'd2);
    chk("f5_paused_busy", 32'(bus.busy), 32'd0);
    chk("f5_paused_starts", cur_starts, 32'd2);
    bus.run = 1'b1;
    tick();
    tick();
    chk("f5_resume_lat", 32'(bus.step_start), 32'd1);
    wait_fr(5, "f5_frame_ready");
    chk("f5_steps", frame_starts, 32'd4);
    chk("f5_fr_lat", fr_cyc - last_done_cyc, 32'd3);
    stream_frame(EXP_BEATS, -1, 0, 1'b1);
    after_frame("f5", EXP_BEATS);

    // Frame 6: asynchronous reset mid-stream.
    wait_fr(6, "f6_frame_ready");
    bus.m00_axis_tvalid = 1'b1;
    bus.m00_axis_tready = 1'b1;
    bus.m00_axis_tlast  = 1'b0;
    repeat (100) tick();
    #2;
    rst_n = 1'b0;
    bus.run = 1'b0;
    #1;
    chk("arst_bram_sel", 32'(bus.bram_sel), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_frame_count", 32'(bus.frame_count), 32'd0);
    chk("arst_step_count", 32'(bus.step_count), 32'd0);
    chk("arst_errs", 32'({bus.err_len, bus.err_step, bus.err_stall}), 32'd0);
    bus.m00_axis_tvalid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    n0 = n_fr;
    repeat (20) tick();
    chk("post_rst_no_start", cur_starts, 32'd0);
    chk("post_rst_no_frame", n_fr, n0);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    chk("post_rst_err_step", 32'(bus.err_step), 32'd0);
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    chk("spurious_err_step", 32'(bus.err_step), 32'd1);
    tick();
    chk("spurious_ignored", 32'(bus.busy), 32'd0);
    chk("spurious_step_count", 32'(bus.step_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
